// File: rtl/common_pkg.sv
// common_pkg: shared types for the skid-buffered stream demultiplexer
package common_pkg;
  typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_t;
endpackage

// File: rtl/skid_buf.sv
// skid_buf: single-channel 2-entry buffer (main + skid register) with valid/ready output
module skid_buf
  import common_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  output logic          can_accept,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);
  skid_state_t   r_state, w_next;
  logic [DW-1:0] r_main, r_skid;
  logic          w_pop;
  assign w_pop      = out_valid && out_ready;
  assign can_accept = r_state != SKID_FULL;
  assign out_valid  = r_state != SKID_EMPTY;
  assign out_data   = r_main;
  // Next state: flush empties the channel, otherwise occupancy follows push/pop
  always_comb begin
    w_next = r_state;
    if (flush) w_next = SKID_EMPTY;
    else
      case (r_state)
        SKID_EMPTY: w_next = push ? SKID_ONE : SKID_EMPTY;
        SKID_ONE:   w_next = (push && !w_pop) ? SKID_FULL : (w_pop && !push) ? SKID_EMPTY : SKID_ONE;
        SKID_FULL:  w_next = w_pop ? SKID_ONE : SKID_FULL;
        default:    w_next = SKID_EMPTY;
      endcase
  end
  // State register; reset outranks flush
  always_ff @(posedge clk) r_state <= !rst_n ? SKID_EMPTY : w_next;
  // Data: head register loads the input when it becomes/stays head, or the skid word when draining FULL
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (!flush) begin
      if (r_state == SKID_FULL) begin
        if (w_pop) r_main <= r_skid;
      end else if (push) begin
        if (r_state == SKID_EMPTY || w_pop) r_main <= data_in;
        else r_skid <= data_in;
      end
    end
endmodule

// File: rtl/demux1_2_skid.sv
// demux1_2_skid: 1-to-2 stream demultiplexer with an independent 2-entry skid buffer per output
module demux1_2_skid #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [DW-1:0] out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [DW-1:0] out1_data
);
  logic w_acc0, w_acc1, w_push0, w_push1;
  assign in_ready = !flush && (sel ? w_acc1 : w_acc0);
  assign w_push0  = in_valid && in_ready && !sel;
  assign w_push1  = in_valid && in_ready && sel;
  skid_buf #(.DW(DW)) u_ch0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(w_push0), .data_in(in_data),
    .can_accept(w_acc0), .out_valid(out0_valid), .out_ready(out0_ready), .out_data(out0_data)
  );
  skid_buf #(.DW(DW)) u_ch1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(w_push1), .data_in(in_data),
    .can_accept(w_acc1), .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data)
  );
endmodule

// File: tb/tb_demux1_2_skid.sv
// tb_demux1_2_skid: directed scoreboard bench for the skid-buffered 1:2 demux
module tb_demux1_2_skid;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, sel;
  logic out0_valid, out0_ready, out1_valid, out1_ready;
  logic [DW-1:0] in_data, out0_data, out1_data;
  logic [DW-1:0] q0[$], q1[$];
  int checks = 0, failures = 0;
  bit last_acc;
  always #5 clk = ~clk;
  demux1_2_skid #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sel(sel), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out0_data(out0_data), .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
  );
  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one cycle: compare outputs against the queue model, then advance the model across the edge
  task automatic tick();
    bit rdy, p0, p1;
    #1;
    last_acc = 1'b0;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      rdy = !flush && (sel ? q1.size() < 2 : q0.size() < 2);
      chk("in_ready", DW'(in_ready), DW'(rdy));
      chk("out0_valid", DW'(out0_valid), DW'(q0.size() != 0));
      chk("out1_valid", DW'(out1_valid), DW'(q1.size() != 0));
      if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
      if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
      p0 = q0.size() != 0 && out0_ready;
      p1 = q1.size() != 0 && out1_ready;
      last_acc = in_valid && rdy;
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (last_acc) begin
          if (sel) q1.push_back(in_data);
          else q0.push_back(in_data);
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic send(bit s, logic [DW-1:0] d);
    int n = 0;
    sel = s;
    in_data = d;
    in_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    chk("send_accepted", DW'(last_acc), DW'(1'b1));
    in_valid = 1'b0;
  endtask
  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; sel = 1'b0; in_data = 32'h1111_1111;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_out0_valid", DW'(out0_valid), '0);
    chk("rst_out1_valid", DW'(out1_valid), '0);
    chk("rst_out0_data", out0_data, '0);
    chk("rst_out1_data", out1_data, '0);
    in_valid = 1'b0;
    tick();
    send(1'b0, 32'hDEADBEEF);
    chk("t2_out0_valid", DW'(out0_valid), DW'(1'b1));
    chk("t2_out0_data", out0_data, 32'hDEADBEEF);
    chk("t2_out1_valid", DW'(out1_valid), '0);
    idle(2);
    out1_ready = 1'b0; sel = 1'b1; in_valid = 1'b1;
    in_data = 32'hAAAA_0001; tick();
    in_data = 32'hBBBB_0002; tick();
    in_data = 32'hCCCC_0003; tick();
    chk("t3_c_rejected", DW'(last_acc), '0);
    chk("t3_out1_head", out1_data, 32'hAAAA_0001);
    out1_ready = 1'b1;
    send(1'b1, 32'hCCCC_0003);
    idle(4);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = i[0];
      in_data = 32'h4000_0000 + i;
      tick();
      chk("t4_accept", DW'(last_acc), DW'(1'b1));
    end
    idle(3);
    out0_ready = 1'b0;
    send(1'b0, 32'h5000_0001);
    send(1'b0, 32'h5000_0002);
    sel = 1'b0; in_valid = 1'b1; flush = 1'b1;
    tick();
    chk("t5_flush_no_accept", DW'(last_acc), '0);
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_out0_empty", DW'(out0_valid), '0);
    tick();
    out0_ready = 1'b1;
    idle(2);
    out0_ready = 1'b0;
    send(1'b0, 32'h6000_00A1);
    send(1'b0, 32'h6000_00A2);
    sel = 1'b1; out1_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h6100_0000 + i;
      tick();
      chk("t6_b2b", DW'(last_acc), DW'(1'b1));
      chk("t6_out0_hold", out0_data, 32'h6000_00A1);
    end
    out0_ready = 1'b1;
    idle(4);
    out1_ready = 1'b0;
    send(1'b1, 32'h7000_0001);
    send(1'b1, 32'h7000_0002);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_out1_valid", DW'(out1_valid), '0);
    chk("mid_rst_out1_data", out1_data, '0);
    out1_ready = 1'b1;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
